// File: rtl/shf_pkg.sv
// ---------------------------------------------------------------------------
// shf_pkg
//  Shared definitions for the shifter arbiter slice: datapath widths, the
//  operation encodings presented on rN_op, the arbiter FSM state type and the
//  latched request record.
// ---------------------------------------------------------------------------
package shf_pkg;

   localparam int DW  = 8;   // operand / result width
   localparam int SHW = 3;   // shift-amount width (0..7)

   localparam logic [1:0] OP_SRA = 2'b00;   // arithmetic right (sign fill)
   localparam logic [1:0] OP_SRL = 2'b01;   // logical right (zero fill)
   localparam logic [1:0] OP_SLL = 2'b10;   // logical left; 2'b11 also shifts left

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Everything captured from the winning requester at accept time.
   typedef struct packed {
      logic [DW-1:0]  din;
      logic [SHW-1:0] shamt;
      logic [1:0]     op;
      logic           owner;   // 0 = r0, 1 = r1
   } req_t;

endpackage

// File: rtl/barrel_shifter.sv
// ---------------------------------------------------------------------------
// barrel_shifter
//  Purely combinational 8-bit shifter shared by the arbiter.
//  Ports:
//   din    in  DW   operand
//   shamt  in  SHW  shift amount, 0..7 (0 passes din through)
//   a_r    in  1    1 = shift left, 0 = shift right
//   l_r    in  1    right shifts only: 1 = zero fill, 0 = sign fill
//   dout   out DW   result
// ---------------------------------------------------------------------------
module barrel_shifter
   import shf_pkg::*;
(
   input  logic [DW-1:0]  din,
   input  logic [SHW-1:0] shamt,
   input  logic           a_r,
   input  logic           l_r,
   output logic [DW-1:0]  dout
);

   logic signed [DW-1:0] din_s;
   logic signed [DW-1:0] sra_s;

   assign din_s = din;
   assign sra_s = din_s >>> shamt;

   always_comb begin
      if (a_r) begin
         dout = din << shamt;
      end else if (l_r) begin
         dout = din >> shamt;
      end else begin
         dout = sra_s;
      end
   end

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//  Two-way round-robin grant logic (combinational). The priority pointer is
//  held by the caller so that it only moves when a grant is actually taken.
//  Ports:
//   req      in  2  request vector, bit N = requester N
//   prio     in  1  requester that wins a tie (0 = r0, 1 = r1)
//   advance  in  1  grants are only issued while the caller can accept
//   gnt      out 2  one-hot grant (all zero when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   input  logic       advance,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (advance) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/shf_arbiter.sv
// ---------------------------------------------------------------------------
// shf_arbiter
//  Shares one barrel_shifter between two requesters with valid/ready
//  handshakes. Round-robin arbitration, one operation in flight, operands and
//  result registered. Each requester has its own response channel; only the
//  owner of the in-flight op ever sees rspN_valid.
//  Sequence: IDLE (accept) -> SHIFT (register result) -> RESP (hold until
//  the owner takes it) -> IDLE.
//
//  Optional feature: define SHF_ARB_PERF_EN to add saturating performance
//  counters (perf_gnt0, perf_gnt1, perf_stall) of width PERF_W. Without the
//  macro those ports and their logic do not exist.
//
//  Ports:
//   clk, rst             clock; asynchronous active-high reset
//   rN_valid/rN_ready    request handshake from requester N
//   rN_din/shamt/op      operand, shift amount, operation (see shf_pkg)
//   rspN_valid/ready     response handshake to requester N
//   rspN_data            shifted result
//   perf_gnt0/1          accepted requests per requester (SHF_ARB_PERF_EN)
//   perf_stall           RESP cycles with the owner not ready (SHF_ARB_PERF_EN)
// ---------------------------------------------------------------------------
module shf_arbiter
   import shf_pkg::*;
#(
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DW-1:0]     r0_din,
   input  logic [SHW-1:0]    r0_shamt,
   input  logic [1:0]        r0_op,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DW-1:0]     r1_din,
   input  logic [SHW-1:0]    r1_shamt,
   input  logic [1:0]        r1_op,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DW-1:0]     rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DW-1:0]     rsp1_data
`ifdef SHF_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_gnt0,
   output logic [PERF_W-1:0] perf_gnt1,
   output logic [PERF_W-1:0] perf_stall
`endif
);

   if (PERF_W < 1) begin : g_perf_w_chk
      $error("shf_arbiter: PERF_W must be at least 1");
   end

   state_t        state_q, state_d;
   logic          prio_q, prio_d;
   req_t          req_q, req_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;

   logic [1:0]    gnt;
   logic [DW-1:0] shf_dout;
   logic          owner_rdy;

   // Grants only while IDLE and out of reset, so ready is never seen high
   // while the shifter is busy or the block is being reset.
   rr_arb2 u_arb (
      .req     ({r1_valid, r0_valid}),
      .prio    (prio_q),
      .advance ((state_q == IDLE) && !rst),
      .gnt     (gnt)
   );

   assign r0_ready = gnt[0];
   assign r1_ready = gnt[1];

   // op[1] selects left; op[0] selects zero fill for right shifts.
   barrel_shifter u_shf (
      .din   (req_q.din),
      .shamt (req_q.shamt),
      .a_r   (req_q.op[1]),
      .l_r   (req_q.op[0]),
      .dout  (shf_dout)
   );

   assign owner_rdy = req_q.owner ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      req_d      = req_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               req_d.din   = gnt[1] ? r1_din   : r0_din;
               req_d.shamt = gnt[1] ? r1_shamt : r0_shamt;
               req_d.op    = gnt[1] ? r1_op    : r0_op;
               req_d.owner = gnt[1];
               // Hand priority to the requester that was not just served.
               prio_d      = gnt[0];
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            rsp_data_d = shf_dout;
            state_d    = RESP;
         end
         RESP: begin
            if (owner_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         req_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         req_q      <= req_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Response valid is decoded from registered state, so it drops in the same
   // instant reset is asserted and the non-owner channel stays low.
   assign rsp0_valid = (state_q == RESP) && !req_q.owner;
   assign rsp1_valid = (state_q == RESP) &&  req_q.owner;
   assign rsp0_data  = rsp_data_q;
   assign rsp1_data  = rsp_data_q;

`ifdef SHF_ARB_PERF_EN
   logic [PERF_W-1:0] perf_gnt0_q, perf_gnt0_d;
   logic [PERF_W-1:0] perf_gnt1_q, perf_gnt1_d;
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      perf_gnt0_d  = perf_gnt0_q;
      perf_gnt1_d  = perf_gnt1_q;
      perf_stall_d = perf_stall_q;
      // A grant implies the matching valid, so gnt marks a handshake.
      if (gnt[0]) perf_gnt0_d = sat_inc(perf_gnt0_q);
      if (gnt[1]) perf_gnt1_d = sat_inc(perf_gnt1_q);
      if ((state_q == RESP) && !owner_rdy) perf_stall_d = sat_inc(perf_stall_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_gnt0_q  <= '0;
         perf_gnt1_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_gnt0_q  <= perf_gnt0_d;
         perf_gnt1_q  <= perf_gnt1_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_gnt0  = perf_gnt0_q;
   assign perf_gnt1  = perf_gnt1_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_shf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shf_arbiter
//  Directed stimulus with hand-computed results. Each accepted request pushes
//  its expected response into a scoreboard queue; an independent monitor pops
//  and compares whenever a response handshake happens.
// ---------------------------------------------------------------------------
module tb_shf_arbiter;
   import shf_pkg::*;

   localparam int PW = 3;

   logic       clk;
   logic       rst;
   logic       r0_valid, r1_valid;
   logic       r0_ready, r1_ready;
   logic [7:0] r0_din, r1_din;
   logic [2:0] r0_shamt, r1_shamt;
   logic [1:0] r0_op, r1_op;
   logic       rsp0_valid, rsp1_valid;
   logic       rsp0_ready, rsp1_ready;
   logic [7:0] rsp0_data, rsp1_data;
`ifdef SHF_ARB_PERF_EN
   logic [PW-1:0] perf_gnt0, perf_gnt1, perf_stall;
`endif

   shf_arbiter #(.PERF_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .r0_valid   (r0_valid),
      .r0_ready   (r0_ready),
      .r0_din     (r0_din),
      .r0_shamt   (r0_shamt),
      .r0_op      (r0_op),
      .r1_valid   (r1_valid),
      .r1_ready   (r1_ready),
      .r1_din     (r1_din),
      .r1_shamt   (r1_shamt),
      .r1_op      (r1_op),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data)
`ifdef SHF_ARB_PERF_EN
      ,
      .perf_gnt0  (perf_gnt0),
      .perf_gnt1  (perf_gnt1),
      .perf_stall (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         id;
      logic [7:0] data;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   last_acc[2];
   int   hs_cyc = 0;

   // Requesters must hold valid and operands until accepted.
   a_hold0: assert property (@(posedge clk) disable iff (rst)
      (r0_valid && !r0_ready) |=> (r0_valid && $stable({r0_din, r0_shamt, r0_op})));
   a_hold1: assert property (@(posedge clk) disable iff (rst)
      (r1_valid && !r1_ready) |=> (r1_valid && $stable({r1_din, r1_shamt, r1_op})));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic issue(input int n, input logic [7:0] din, input logic [2:0] sh,
                        input logic [1:0] op, input logic [7:0] exp);
      bit done = 0;
      if (n == 0) begin
         r0_valid = 1'b1; r0_din = din; r0_shamt = sh; r0_op = op;
      end else begin
         r1_valid = 1'b1; r1_din = din; r1_shamt = sh; r1_op = op;
      end
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (((n == 0) ? r0_ready : r1_ready) === 1'b1) begin
            sb.push_back('{n, exp, cyc});
            glog.push_back(n);
            last_acc[n] = cyc;
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (n == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL accept_r%0d actual=not_accepted required=accepted", n);
      end
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(posedge clk); #1;
         if (sb.size() == 0) done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL drain actual=%0d_pending required=0", sb.size());
      end
   endtask

   // Monitor: latency, hold under backpressure, exclusive valids, data match.
   initial begin : mon
      bit         pv;
      logic [7:0] pd;
      bit         v, id, rdy;
      logic [7:0] d;
      pv = 0; pd = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 0;
         end else begin
            if (rsp0_valid && rsp1_valid) chk("rsp_exclusive", 32'd1, 32'd0);
            v   = rsp0_valid || rsp1_valid;
            id  = rsp1_valid;
            d   = id ? rsp1_data : rsp0_data;
            rdy = id ? rsp1_ready : rsp0_ready;
            if (v) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", {31'd0, v}, 32'd0);
               end else begin
                  if (!pv) chk("latency", cyc - sb[0].acc, 32'd2);
                  else     chk("rsp_hold", d, pd);
                  if (rdy) begin
                     chk("rsp_owner", id, sb[0].id);
                     chk("rsp_data", d, sb[0].data);
                     void'(sb.pop_front());
                     hs_cyc = cyc;
                  end
               end
            end
            pv = v && !rdy;
            pd = d;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_din = '0; r0_shamt = '0; r0_op = '0;
      r1_din = '0; r1_shamt = '0; r1_op = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset state: ready gated even with valids high, responses empty.
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_data", rsp0_data, 8'h00);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Three operations on the same operand.
      issue(0, 8'h96, 3'd3, OP_SRA, 8'hF2); wait_idle();
      issue(0, 8'h96, 3'd3, OP_SRL, 8'h12); wait_idle();
      issue(0, 8'h96, 3'd3, OP_SLL, 8'hB0); wait_idle();

      // Both requesters contending: alternate grants.
      rst = 1'b1; #1;
      @(posedge clk); #1;
      rst = 1'b0;
      glog.delete();
      fork
         issue(0, 8'h0F, 3'd1, OP_SLL, 8'h1E);
         issue(1, 8'hF0, 3'd4, OP_SRL, 8'h0F);
      join
      fork
         issue(0, 8'h81, 3'd1, OP_SRA, 8'hC0);
         issue(1, 8'h3C, 3'd2, OP_SLL, 8'hF0);
      join
      wait_idle();
      chk("rr_count", glog.size(), 4);
      if (glog.size() == 4) begin
         chk("rr_gnt0", glog[0], 0);
         chk("rr_gnt1", glog[1], 1);
         chk("rr_gnt2", glog[2], 0);
         chk("rr_gnt3", glog[3], 1);
      end

      // Backpressure on rsp0 while r1 waits.
      rsp0_ready = 1'b0;
      issue(0, 8'h55, 3'd1, OP_SRL, 8'h2A);
      fork
         issue(1, 8'hC3, 3'd2, OP_SRA, 8'hF0);
         begin
            bit seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
               @(negedge clk);
               if (rsp0_valid) seen = 1;
            end
            chk("bp_seen", seen, 1);
            for (int i = 0; i < 5; i++) begin
               chk("bp_rsp0_valid", rsp0_valid, 1);
               chk("bp_rsp0_data", rsp0_data, 8'h2A);
               chk("bp_r1_ready", r1_ready, 0);
               if (i < 4) @(negedge clk);
            end
            @(posedge clk); #1;
            rsp0_ready = 1'b1;
         end
      join
      chk("bp_r1_accept", last_acc[1], hs_cyc + 1);
      wait_idle();

      // Zero shift passes data through; full arithmetic shift of 0x80.
      issue(0, 8'h5A, 3'd0, OP_SRA, 8'h5A); wait_idle();
      issue(1, 8'h5A, 3'd0, OP_SRL, 8'h5A); wait_idle();
      issue(0, 8'h5A, 3'd0, OP_SLL, 8'h5A); wait_idle();
      issue(1, 8'h80, 3'd7, OP_SRA, 8'hFF); wait_idle();

      // Reset during SHIFT drops the op; r0 wins first afterwards.
      issue(0, 8'h12, 3'd1, OP_SLL, 8'h24);
      rst = 1'b1;
      #1;
      chk("rst_shift_rsp0_valid", rsp0_valid, 0);
      chk("rst_shift_rsp1_valid", rsp1_valid, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_stale_rsp", {31'd0, rsp0_valid | rsp1_valid}, 0);
      end
      @(posedge clk); #1;
      glog.delete();
      fork
         issue(0, 8'h01, 3'd7, OP_SLL, 8'h80);
         issue(1, 8'hFF, 3'd7, OP_SRL, 8'h01);
      join
      wait_idle();
      chk("post_rst_first", (glog.size() > 0) ? glog[0] : -1, 0);

`ifdef SHF_ARB_PERF_EN
      rst = 1'b1; #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("perf_rst_gnt0", perf_gnt0, 0);
      rsp0_ready = 1'b0;
      issue(0, 8'h01, 3'd1, OP_SLL, 8'h02);
      begin
         bit seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp0_valid) seen = 1;
         end
         chk("perf_stall_seen", seen, 1);
         repeat (3) @(negedge clk);
         @(posedge clk); #1;
         rsp0_ready = 1'b1;
      end
      wait_idle();
      issue(0, 8'h02, 3'd1, OP_SLL, 8'h04); wait_idle();
      issue(0, 8'h04, 3'd1, OP_SLL, 8'h08); wait_idle();
      issue(1, 8'h08, 3'd1, OP_SRL, 8'h04); wait_idle();
      issue(1, 8'h10, 3'd1, OP_SRL, 8'h08); wait_idle();
      chk("perf_gnt0", perf_gnt0, 3);
      chk("perf_gnt1", perf_gnt1, 2);
      chk("perf_stall", perf_stall, 4);
      for (int i = 0; i < 5; i++) begin
         issue(0, 8'h01, 3'd0, OP_SRL, 8'h01);
         wait_idle();
      end
      chk("perf_gnt0_sat", perf_gnt0, 7);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
